// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and constants for the JPEG frame sequencer.
package jpeg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAITBLK,
        IMAGE,
        FLUSH,
        DONE
    } fsm_t;

    localparam int BLK_DIM     = 8;
    localparam int BLK_PIX     = 64;
    localparam int LEVEL_SHIFT = 128;

    // Unsigned sample to signed: subtracting 128 from an 8-bit value is the
    // same as flipping its MSB.
    function automatic logic [7:0] level_shift(input logic [7:0] sample);
        return sample ^ 8'(LEVEL_SHIFT);
    endfunction

endpackage

// File: rtl/jpeg_pix_fifo.sv
// Two-entry pixel FIFO between the memory read port and the pipeline input.
module jpeg_pix_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written when full.
    assign w_do_push = push && (!full || w_do_pop);

    // Storage write on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; push+pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer: scans a raster greyscale image in 8x8 block order,
// level-shifts each sample and streams it to the JPEG pipeline, then runs
// the end-of-image / flush handshake.
module jpeg_frame_ctrl
    import jpeg_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_ext_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  width_blk,
    input  logic [DIM_W-1:0]  height_blk,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       blocks_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              pipe_ena_in,
    output logic [7:0]        pipe_pixel,
    input  logic              pipe_rdy_out,
    input  logic              pipe_done_block,
    output logic              pipe_done_image,
    input  logic              pipe_done_flush
);

    localparam logic [DIM_W-1:0]  DIM_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [2:0]        LAST_IDX = 3'(BLK_DIM - 1);

    fsm_t              r_state;
    fsm_t              w_state_next;

    // Scan position and frame geometry captured at start
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_bx;
    logic [DIM_W-1:0]  r_by;
    logic [2:0]        r_col;
    logic [2:0]        r_row;

    // Incremental address bookkeeping
    logic [ADDR_W-1:0] r_cur_addr;    // address of the next read to issue
    logic [ADDR_W-1:0] r_row_start;   // first pixel of current block row r
    logic [ADDR_W-1:0] r_blk_start;   // pixel (0,0) of current block
    logic [ADDR_W-1:0] r_brow_start;  // pixel (0,0) of first block in block row
    logic [ADDR_W-1:0] r_stride;      // image row stride = width_blk*8
    logic [ADDR_W-1:0] r_bstride;     // block-row stride = width_blk*64
    logic [ADDR_W-1:0] r_last_addr;   // last issued address, shown when idle
    logic [ADDR_W-1:0] w_row_next;
    logic [ADDR_W-1:0] w_blk_next;
    logic [ADDR_W-1:0] w_brow_next;

    logic              r_rd_done;     // every pixel of the frame has been read
    logic              r_inflight;    // read issued last cycle, data arrives now
    logic [15:0]       r_nblk;
    logic [15:0]       r_blk_cnt;

    logic              w_start_ok;
    logic              w_issue;
    logic              w_row_last;
    logic              w_blk_last;
    logic              w_feed_done;
    logic [7:0]        w_fifo_dout;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [2:0]        w_occupancy;

    assign w_start_ok  = (r_state == IDLE) && start &&
                         (width_blk != '0) && (height_blk != '0);
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_issue     = (r_state == FEED) && !r_rd_done && !w_fifo_full &&
                         (w_occupancy < 3'd2);
    assign w_row_last  = (r_col == LAST_IDX);
    assign w_blk_last  = ({r_row, r_col} == 6'(BLK_PIX - 1));
    assign w_row_next  = r_row_start + r_stride;
    assign w_blk_next  = r_blk_start + ADDR_W'(BLK_DIM);
    assign w_brow_next = r_brow_start + r_bstride;
    assign w_feed_done = r_rd_done && w_fifo_empty && !r_inflight;

    assign mem_rd      = w_issue;
    assign mem_addr    = w_issue ? r_cur_addr : r_last_addr;
    assign pipe_ena_in = !w_fifo_empty && pipe_rdy_out;
    assign pipe_pixel  = pipe_ena_in ? w_fifo_dout : 8'h00;
    assign blocks_done = r_blk_cnt;

    jpeg_pix_fifo #(
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_ext_n),
        .push  (r_inflight),
        .din   (level_shift(mem_rdata)),
        .pop   (pipe_ena_in),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state and FSM-driven outputs.
    always_comb begin
        w_state_next    = r_state;
        busy            = (r_state != IDLE) && (r_state != DONE);
        done            = 1'b0;
        pipe_done_image = 1'b0;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = FEED;
            FEED:    if (w_feed_done) w_state_next = WAITBLK;
            WAITBLK: if (r_blk_cnt == r_nblk) w_state_next = IMAGE;
            IMAGE: begin
                pipe_done_image = 1'b1;
                w_state_next    = FLUSH;
            end
            FLUSH:   if (pipe_done_flush) w_state_next = DONE;
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Marks the read issued this cycle so its data is pushed next cycle.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) r_inflight <= 1'b0;
        else            r_inflight <= w_issue;
    end

    // Block-order address walker: +1 along a row, row stride at a row
    // change, +8 to the next block, block-row stride at the end of a block row.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            r_w          <= '0;
            r_h          <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_cur_addr   <= '0;
            r_row_start  <= '0;
            r_blk_start  <= '0;
            r_brow_start <= '0;
            r_stride     <= '0;
            r_bstride    <= '0;
            r_last_addr  <= '0;
            r_rd_done    <= 1'b0;
        end else if (w_start_ok) begin
            r_w          <= width_blk;
            r_h          <= height_blk;
            r_bx         <= '0;
            r_by         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_cur_addr   <= base_addr;
            r_row_start  <= base_addr;
            r_blk_start  <= base_addr;
            r_brow_start <= base_addr;
            r_stride     <= ADDR_W'(width_blk) << 3;
            r_bstride    <= ADDR_W'(width_blk) << 6;
            r_rd_done    <= 1'b0;
        end else if (w_issue) begin
            r_last_addr <= r_cur_addr;
            if (!w_row_last) begin
                r_col      <= r_col + 3'd1;
                r_cur_addr <= r_cur_addr + ADDR_ONE;
            end else if (!w_blk_last) begin
                r_col       <= '0;
                r_row       <= r_row + 3'd1;
                r_row_start <= w_row_next;
                r_cur_addr  <= w_row_next;
            end else begin
                r_col <= '0;
                r_row <= '0;
                if (r_bx != r_w - DIM_ONE) begin
                    r_bx        <= r_bx + DIM_ONE;
                    r_blk_start <= w_blk_next;
                    r_row_start <= w_blk_next;
                    r_cur_addr  <= w_blk_next;
                end else begin
                    r_bx <= '0;
                    if (r_by != r_h - DIM_ONE) begin
                        r_by         <= r_by + DIM_ONE;
                        r_brow_start <= w_brow_next;
                        r_blk_start  <= w_brow_next;
                        r_row_start  <= w_brow_next;
                        r_cur_addr   <= w_brow_next;
                    end else begin
                        r_rd_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Block-completion counter, saturating at the frame's block total.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            r_nblk    <= '0;
            r_blk_cnt <= '0;
        end else if (w_start_ok) begin
            r_nblk    <= 16'(width_blk) * 16'(height_blk);
            r_blk_cnt <= '0;
        end else if ((r_state != IDLE) && pipe_done_block && (r_blk_cnt < r_nblk)) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Directed bench for jpeg_frame_ctrl with a byte memory model and a
// pipeline model that answers every 64 accepted pixels with done_block.
module tb_jpeg_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_ext_n;
    logic        start;
    logic [7:0]  width_blk;
    logic [7:0]  height_blk;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic [15:0] blocks_done;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        pipe_ena_in;
    logic [7:0]  pipe_pixel;
    logic        pipe_rdy_out;
    logic        pipe_done_block;
    logic        pipe_done_image;
    logic        pipe_done_flush;

    jpeg_frame_ctrl #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk             (clk),
        .rst_ext_n       (rst_ext_n),
        .start           (start),
        .width_blk       (width_blk),
        .height_blk      (height_blk),
        .base_addr       (base_addr),
        .busy            (busy),
        .done            (done),
        .blocks_done     (blocks_done),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .pipe_ena_in     (pipe_ena_in),
        .pipe_pixel      (pipe_pixel),
        .pipe_rdy_out    (pipe_rdy_out),
        .pipe_done_block (pipe_done_block),
        .pipe_done_image (pipe_done_image),
        .pipe_done_flush (pipe_done_flush)
    );

    always #5 clk = ~clk;

    logic [7:0] tbmem [0:65535];

    // Synchronous memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= tbmem[mem_addr];
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor (sampled on the falling edge)
    logic [15:0] q_addr [$];
    logic [7:0]  q_pix  [$];
    int rd_total = 0, pop_total = 0, img_cnt = 0, done_cnt = 0;
    int img_cyc = -1, done_cyc = -1, flush_cyc = -1, bd_cyc = -1;
    int outstanding = 0, max_out = 0, rd_viol = 0, zero_viol = 0;
    logic busy_at_done = 1'b1;
    logic [15:0] bd_prev = 16'h0;

    always @(negedge clk) begin
        if (!rst_ext_n) begin
            outstanding <= 0;
            bd_prev     <= blocks_done;
        end else begin
            if (mem_rd) begin
                q_addr.push_back(mem_addr);
                rd_total <= rd_total + 1;
                if (outstanding >= 2) rd_viol <= rd_viol + 1;
            end
            if (pipe_ena_in) begin
                q_pix.push_back(pipe_pixel);
                pop_total <= pop_total + 1;
            end
            if (!pipe_ena_in && pipe_pixel != 8'h00) zero_viol <= zero_viol + 1;
            outstanding <= outstanding + int'(mem_rd) - int'(pipe_ena_in);
            if (outstanding + int'(mem_rd) > max_out) max_out <= outstanding + int'(mem_rd);
            if (pipe_done_image) begin
                img_cnt <= img_cnt + 1;
                img_cyc <= cyc_cnt;
            end
            if (done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc_cnt;
                busy_at_done <= busy;
            end
            if (pipe_done_flush) flush_cyc <= cyc_cnt;
            if (blocks_done != bd_prev) bd_cyc <= cyc_cnt;
            bd_prev <= blocks_done;
        end
    end

    int tests = 0;
    int fails = 0;
    int rdy_pct = 100;
    bit auto_blk = 1'b0;
    int blk_sent = 0;
    int pop_base = 0;
    int a0_g = 0;
    int p0_g = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int a);
        int v;
        v = int'(tbmem[a & 16'hFFFF]) - 128;
        return 8'(v);
    endfunction

    // One clock: drive ready and the block-done model, then settle past the edge.
    task automatic step();
        pipe_rdy_out = ($urandom_range(0, 99) < rdy_pct);
        if (auto_blk) begin
            if ((pop_total - pop_base) / 64 > blk_sent) begin
                pipe_done_block = 1'b1;
                blk_sent++;
            end else begin
                pipe_done_block = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input int base, input int pct);
        a0_g = q_addr.size();
        p0_g = q_pix.size();
        pop_base = pop_total;
        blk_sent = 0;
        rdy_pct = pct;
        auto_blk = 1'b1;
        width_blk = 8'(w);
        height_blk = 8'(h);
        base_addr = 16'(base);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done_image, raise done_flush five cycles later, wait for done.
    task automatic finish_frame(input string tag, input int max_cyc);
        int n;
        int i0;
        int d0;
        i0 = img_cnt;
        d0 = done_cnt;
        n = 0;
        while (img_cnt == i0 && n < max_cyc) begin
            step();
            n++;
        end
        chk({tag, "_img_seen"}, img_cnt - i0, 1);
        repeat (4) step();
        pipe_done_flush = 1'b1;
        step();
        pipe_done_flush = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        step();
        step();
    endtask

    task automatic check_frame(input string tag, input int w, input int h, input int base);
        int idx;
        int ea;
        chk({tag, "_nrd"}, q_addr.size() - a0_g, w * h * 64);
        chk({tag, "_npix"}, q_pix.size() - p0_g, w * h * 64);
        idx = 0;
        for (int by = 0; by < h; by++)
            for (int bx = 0; bx < w; bx++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        ea = (base + (by * 8 + r) * w * 8 + bx * 8 + c) & 32'hFFFF;
                        if (a0_g + idx < q_addr.size())
                            chk($sformatf("%s_addr%0d", tag, idx), 32'(q_addr[a0_g + idx]), ea);
                        if (p0_g + idx < q_pix.size())
                            chk($sformatf("%s_pix%0d", tag, idx), 32'(q_pix[p0_g + idx]), 32'(exp_pix(ea)));
                        idx++;
                    end
    endtask

    initial begin
        int n;
        int r0;
        int d0;
        int i0;
        for (int a = 0; a < 65536; a++) tbmem[a] = 8'(a ^ (a >> 8));
        rst_ext_n = 1'b0;
        start = 1'b0;
        width_blk = 8'd0;
        height_blk = 8'd0;
        base_addr = 16'h0;
        pipe_rdy_out = 1'b0;
        pipe_done_block = 1'b0;
        pipe_done_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ena", pipe_ena_in, 0);
        chk("rst_img", pipe_done_image, 0);
        chk("rst_blocks", blocks_done, 0);
        rst_ext_n = 1'b1;
        step();

        // 1x1 frame, base 0, ready always high
        start_frame(1, 1, 0, 100);
        chk("t1_busy", busy, 1);
        finish_frame("t1", 400);
        check_frame("t1", 1, 1, 0);
        chk("t1_pix0", 32'(q_pix[p0_g]), 32'h80);
        chk("t1_pix63", 32'(q_pix[p0_g + 63]), 32'hBF);
        chk("t1_img_after_bd", img_cyc, bd_cyc + 1);
        chk("t1_done_after_flush", done_cyc, flush_cyc + 1);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_blocks", blocks_done, 1);
        chk("t1_img_cnt", img_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);

        // 2x2 frame at 0x100
        start_frame(2, 2, 32'h100, 100);
        chk("t2_bd_cleared", blocks_done, 0);
        finish_frame("t2", 2000);
        check_frame("t2", 2, 2, 32'h100);
        chk("t2_addr9", 32'(q_addr[a0_g + 9]), 32'h111);
        chk("t2_blk1", 32'(q_addr[a0_g + 64]), 32'h108);
        chk("t2_blk2", 32'(q_addr[a0_g + 128]), 32'h180);
        chk("t2_blocks", blocks_done, 4);

        // Backpressure, ready high about 30% of cycles
        start_frame(1, 1, 0, 30);
        finish_frame("t3", 3000);
        check_frame("t3", 1, 1, 0);
        chk("t3_rd_viol", rd_viol, 0);
        chk("t3_max_ahead_ok", (max_out <= 2), 1);
        chk("t3_zero_when_idle", zero_viol, 0);
        rdy_pct = 100;

        // Asynchronous reset mid-feed after 37 pixels
        start_frame(1, 1, 0, 100);
        auto_blk = 1'b0;
        n = 0;
        while ((pop_total - pop_base) < 37 && n < 300) begin
            step();
            n++;
        end
        chk("t4_reached37", pop_total - pop_base, 37);
        chk("t4_busy_before", busy, 1);
        rst_ext_n = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_mem_rd", mem_rd, 0);
        chk("t4_mem_addr", mem_addr, 0);
        chk("t4_ena", pipe_ena_in, 0);
        chk("t4_pixel", pipe_pixel, 0);
        chk("t4_blocks", blocks_done, 0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_ext_n = 1'b1;
        step();
        chk("t4_no_done", done_cnt - d0, 0);
        start_frame(1, 1, 0, 100);
        chk("t4_new_bd", blocks_done, 0);
        finish_frame("t4", 400);
        check_frame("t4", 1, 1, 0);

        // Ignored starts, extra done_block, early done_flush
        d0 = done_cnt;
        r0 = rd_total;
        width_blk = 8'd0;
        height_blk = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("t5_w0_busy", busy, 0);
        width_blk = 8'd1;
        height_blk = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("t5_h0_busy", busy, 0);
        chk("t5_zero_no_reads", rd_total - r0, 0);
        chk("t5_zero_no_done", done_cnt - d0, 0);

        start_frame(1, 1, 0, 100);
        auto_blk = 1'b0;
        i0 = img_cnt;
        n = 0;
        while ((pop_total - pop_base) < 64 && n < 300) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_no_img", img_cnt - i0, 0);
        width_blk = 8'd2;
        height_blk = 8'd2;
        base_addr = 16'h200;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pipe_done_flush = 1'b1;
        step();
        pipe_done_flush = 1'b0;
        step();
        pipe_done_block = 1'b1;
        repeat (3) step();
        pipe_done_block = 1'b0;
        repeat (5) step();
        chk("t5_img_once", img_cnt - i0, 1);
        chk("t5_blocks_sat", blocks_done, 1);
        chk("t5_flush_early_ignored", done_cnt - d0, 0);
        chk("t5_still_busy", busy, 1);
        chk("t5_no_new_reads", rd_total - r0, 64);
        pipe_done_flush = 1'b1;
        step();
        pipe_done_flush = 1'b0;
        step();
        chk("t5_done_once", done_cnt - d0, 1);
        chk("t5_busy_end", busy, 0);
        pipe_done_block = 1'b1;
        step();
        pipe_done_block = 1'b0;
        repeat (5) step();
        chk("t5_no_extra_done", done_cnt - d0, 1);
        chk("t5_blocks_hold", blocks_done, 1);
        check_frame("t5", 1, 1, 0);

        // Address wrap at the top of memory
        start_frame(1, 1, 32'hFFF8, 100);
        finish_frame("t6", 400);
        check_frame("t6", 1, 1, 32'hFFF8);
        chk("t6_row1", 32'(q_addr[a0_g + 8]), 32'h0000);
        chk("t6_last", 32'(q_addr[a0_g + 63]), 32'h0037);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jpeg_frame_ctrl.md
Name: jpeg_frame_ctrl

Overview:
Frame sequencer in front of jpeg_pipeline. On start, it walks a raster 8-bit greyscale image in a pixel memory in 8x8 block order and level-shifts each sample to signed. It feeds samples to the pipeline's ena_in/in_pixel under rdy_out backpressure, counts done_block pulses, then issues done_image and waits for done_flush before reporting frame completion.

Parameters:
ADDR_W, 16, pixel memory address width (byte addressed)
DIM_W, 8, width of block-count dimensions

Ports:
clk  in  1  clock, all logic on posedge
rst_ext_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request
width_blk  in  DIM_W  image width in 8x8 blocks; sampled at accepted start
height_blk  in  DIM_W  image height in blocks; sampled at accepted start
base_addr  in  ADDR_W  address of pixel (0,0); sampled at accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the frame is complete
blocks_done  out  16  done_block pulses counted this frame
mem_rd  out  1  pixel read strobe
mem_addr  out  ADDR_W  read address, valid with mem_rd
mem_rdata  in  8  unsigned pixel; valid exactly 1 cycle after mem_rd
pipe_ena_in  out  1  to pipeline ena_in
pipe_pixel  out  8  to pipeline in_pixel, signed
pipe_rdy_out  in  1  from pipeline rdy_out; pipeline accepts a pixel this cycle
pipe_done_block  in  1  from pipeline done_block
pipe_done_image  out  1  to pipeline done_image
pipe_done_flush  in  1  from pipeline done_flush

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, buffer is empty, counters are cleared. Reset mid-frame aborts the frame with no done pulse. Reads still in flight at reset are discarded.
- Start acceptance: start is accepted only in IDLE with width_blk!=0 and height_blk!=0. If either is 0, start is ignored, busy stays 0 and no done pulse is issued. Start is ignored while busy.
- Totals: N = width_blk*height_blk blocks and P = 64*N pixels.
- Scan order: blocks in raster order (bx fastest, then by). Within each block, row r 0..7 and column c 0..7, with c fastest.
- Address: mem_addr = base_addr + (by*8+r)*(width_blk*8) + bx*8 + c, modulo 2^ADDR_W. Compute it incrementally with no multiplier: add 1 within a row, add the row stride at a row change, and step by +8 or by the block-row stride at block edges.
- Buffer: 2-entry pixel FIFO. mem_rd is issued when pixels remain and (fifo_count + reads_in_flight) < 2. Each read's data is pushed on the following cycle.
- Pixel output: pipe_ena_in = fifo non-empty AND pipe_rdy_out. It is combinational from the FIFO head and registered rdy. A pop happens when pipe_ena_in is high. When pipe_ena_in is low, pipe_pixel is 0.
- Level shift: pipe_pixel = mem_rdata - 128, implemented as MSB inversion. Examples: 0x00 -> -128, 0x80 -> 0, 0xFF -> 127.
- Simultaneous push and pop keep the count unchanged. Peak throughput is 1 pixel/cycle with rdy_out held high.
- FSM states:
  - IDLE: on an accepted start go to FEED; busy goes high.
  - FEED: go to WAITBLK once all P reads have been issued and all P pixels have been popped.
  - WAITBLK: go to IMAGE when blocks_done == N. This may be immediate.
  - IMAGE: pipe_done_image=1 for exactly one cycle, then go to FLUSH.
  - FLUSH: when pipe_done_flush is high, go to DONE.
  - DONE: done=1 for one cycle and busy drops, then go to IDLE.
- blocks_done counts pipe_done_block in every non-IDLE state, saturating at N. Pulses beyond N are ignored. It is cleared on an accepted start and holds its value in IDLE.
- pipe_done_flush outside FLUSH is ignored. pipe_done_block in IDLE is ignored.
- mem_addr holds its last value when mem_rd is 0.

Decomposition:
- Package jpeg_ctrl_pkg contains:
  - enum fsm_t {IDLE, FEED, WAITBLK, IMAGE, FLUSH, DONE};
  - localparams BLK_DIM=8, BLK_PIX=64, LEVEL_SHIFT=128.
- One sub-module, jpeg_pix_fifo: 2-deep, 8-bit, with push/pop/count, full and empty flags, and async active-low reset.
- The address generator and FSM stay inline.

Test Plan:
- 1x1 frame, mem[i]=i, base 0, rdy high: 64 pushes of i-128 in order (-128..-65). Model 4 done_block pulses? No, 1 pulse, then done_image goes high one cycle later. done_flush 5 cycles after that gives done the next cycle and busy=0.
- 2x2 frame, width_blk=2, base 0x100: the first 10 mem_addr values are 0x100..0x107 then 0x110, 0x111. Block 1 starts at 0x108. Block 2 starts at 0x180. Check all 256 addresses against the formula.
- Backpressure, 1x1 frame, rdy_out toggling 1/0 with random 30% high: at most 2 reads ahead of pops, no pixel lost or duplicated, order preserved, mem_rd never issued with the FIFO plus in-flight count at 2.
- Reset asserted asynchronously mid-FEED at pixel 37: all outputs go to 0 immediately. A new 1x1 start afterwards streams pixel 0 first, with blocks_done=0.
- start while busy, plus start with width_blk=0: no effect, no extra done. Extra done_block pulses leave blocks_done at N. Early done_flush during WAITBLK is ignored, and the frame still waits for the pulse in FLUSH.
- Address wrap: base_addr=0xFFF8, 1x1 frame: addresses 0xFFF8..0xFFFF, then row 1 at 0x0000..0x0007 (stride 8, mod 2^16).
